// File: rtl/ps2_scan_receiver_if.sv
// Pin-side and keycode-side signals of the PS/2 scan receiver, bundled as one port.
// master is the receiver; slave is the keyboard pins plus the downstream control stage.
`timescale 1ns/1ps

interface ps2_scan_receiver_if;
    logic        PS2_Clock;
    logic        PS2_Data;
    logic [15:0] KeyCode_Out;
    logic        Code_Valid;
    logic        Frame_Error;
    logic        Busy;

    modport master (
        input  PS2_Clock,
        input  PS2_Data,
        output KeyCode_Out,
        output Code_Valid,
        output Frame_Error,
        output Busy
    );

    modport slave (
        output PS2_Clock,
        output PS2_Data,
        input  KeyCode_Out,
        input  Code_Valid,
        input  Frame_Error,
        input  Busy
    );
endinterface

// File: rtl/ps2_scan_receiver.sv
// Receive-only PS/2 keyboard frame receiver: synchronizes and glitch-filters the pins,
// validates 11-bit frames and keeps a two-byte history of accepted scan codes.
`timescale 1ns/1ps

module ps2_scan_receiver #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    ps2_scan_receiver_if.master   bus
);

    localparam int              IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]      FILT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK
    } state_t;

    logic [1:0]        clk_sync;
    logic [1:0]        data_sync;
    logic              clk_filt;
    logic              clk_filt_q;
    logic [3:0]        filt_cnt;
    logic              sample_evt;
    logic              sample_data;

    state_t            state;
    logic [3:0]        bit_cnt;
    logic [9:0]        shift;
    logic [IDLE_W-1:0] idle_cnt;
    logic [15:0]       key_code;
    logic              code_valid;
    logic              frame_error;
    logic              busy;
    logic              frame_good;

    // Both pins idle high, so the synchronizers reset to 1 to avoid a false start bit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], bus.PS2_Clock};
            data_sync <= {data_sync[0], bus.PS2_Data};
        end
    end

    // The filtered clock only follows the pin after FILTER_LEN consecutive differing
    // samples; the falling edge is then registered into a one-cycle sample event.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_filt    <= 1'b1;
            clk_filt_q  <= 1'b1;
            filt_cnt    <= 4'd0;
            sample_evt  <= 1'b0;
            sample_data <= 1'b1;
        end else begin
            clk_filt_q  <= clk_filt;
            sample_evt  <= clk_filt_q & ~clk_filt;
            sample_data <= data_sync[1];
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= 4'd0;
            end else if (filt_cnt == FILT_LAST) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= 4'd0;
            end else begin
                filt_cnt <= filt_cnt + 4'd1;
            end
        end
    end

    // shift[7:0] = data LSB-first, shift[8] = odd parity, shift[9] = stop
    assign frame_good = (^shift[8:0]) & shift[9];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            shift       <= 10'd0;
            idle_cnt    <= '0;
            key_code    <= 16'h0000;
            code_valid  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            code_valid  <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_evt && !sample_data) begin
                        state    <= RECV;
                        bit_cnt  <= 4'd0;
                        idle_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                RECV: begin
                    if (sample_evt) begin
                        shift    <= {sample_data, shift[9:1]};
                        bit_cnt  <= bit_cnt + 4'd1;
                        idle_cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            state <= CHECK;
                        end
                    end else if (idle_cnt == IDLE_MAX) begin
                        // Stalled frame: drop the partial bits and report it.
                        state       <= IDLE;
                        frame_error <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (frame_good) begin
                        key_code   <= {key_code[7:0], shift[7:0]};
                        code_valid <= 1'b1;
                    end else begin
                        frame_error <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.KeyCode_Out = key_code;
    assign bus.Code_Valid  = code_valid;
    assign bus.Frame_Error = frame_error;
    assign bus.Busy        = busy;

endmodule
